// File: rtl/rr_resource_scheduler.sv
// Round-robin owner scheduler for one shared resource: a grant is held until the owner
// releases it (done or req drop) or its hold budget runs out, then the next requester is served.
module rr_resource_scheduler #(
    parameter int  N_REQ    = 4,
    parameter int  MAX_HOLD = 16,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] done_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic             win_found_s;
    logic [ID_W-1:0]  win_id_s;
    logic             owner_release_s;
    logic             hold_expired_s;

    // Circular first-set scan of req starting at the round-robin pointer.
    always_comb begin
        int idx;
        win_found_s = 1'b0;
        win_id_s    = '0;
        idx         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (req_i[idx] && !win_found_s) begin
                win_found_s = 1'b1;
                win_id_s    = ID_W'(idx);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign owner_release_s = done_i[grant_id_q] | ~req_i[grant_id_q];
    assign hold_expired_s  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found_s) begin
                    grant_d           = '0;
                    grant_d[win_id_s] = 1'b1;
                    grant_id_d        = win_id_s;
                    busy_d            = 1'b1;
                    hold_cnt_d        = '0;
                    ptr_d             = (win_id_s == ID_W'(N_REQ - 1)) ? '0 : (win_id_s + ID_W'(1));
                    state_d           = S_BUSY;
                end else begin
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                end
            end
            S_BUSY: begin
                if (owner_release_s) begin
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                    state_d    = S_RELEASE;
                end else if (hold_expired_s) begin
                    // Pointer already moved past this owner, so others get served first.
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = S_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            S_RELEASE: begin
                state_d   = S_IDLE;
                timeout_d = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Scoreboard bench for rr_resource_scheduler: a cycle model pushes expected outputs per
// driven cycle, which are popped and compared after the following clock edge.
module tb_rr_resource_scheduler;

    localparam int N   = 4;
    localparam int MH  = 8;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_i;
    logic [N-1:0]   done_i;
    logic [N-1:0]   grant_o;
    logic [IDW-1:0] grant_id_o;
    logic           busy_o;
    logic           timeout_o;

    rr_resource_scheduler #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .done_i     (done_i),
        .grant_o    (grant_o),
        .grant_id_o (grant_id_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: m_state 0=idle 1=busy 2=release; m_cnt = grant cycles seen so far.
    int   m_state, m_owner, m_ptr, m_cnt;
    logic m_to;
    logic [7:0] sb_q[$];

    task automatic model_reset();
        m_state = 0; m_owner = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
        sb_q.delete();
    endtask

    function automatic logic [7:0] exp_pack();
        logic [3:0] g;
        logic [1:0] id;
        g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        return {g, id, (m_owner >= 0), m_to};
    endfunction

    task automatic model_step(input logic [3:0] r, input logic [3:0] d);
        bit found;
        case (m_state)
            0: begin
                m_to = 1'b0;
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && r[(m_ptr + k) % N]) begin
                        found   = 1'b1;
                        m_owner = (m_ptr + k) % N;
                    end
                end
                if (found) begin
                    m_ptr = (m_owner + 1) % N; m_cnt = 1; m_state = 1;
                end
            end
            1: begin
                if (d[m_owner] || !r[m_owner]) begin
                    m_owner = -1; m_state = 2; m_to = 1'b0;
                end else if (m_cnt == MH) begin
                    m_owner = -1; m_state = 2; m_to = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            default: begin
                m_state = 0; m_to = 1'b0;
            end
        endcase
        sb_q.push_back(exp_pack());
    endtask

    task automatic cyc(input logic [3:0] r, input logic [3:0] d, input string tag);
        logic [7:0] exp;
        req_i = r; done_i = d;
        model_step(r, d);
        @(posedge clk); #1;
        exp = sb_q.pop_front();
        check_eq(tag, {grant_o, grant_id_o, busy_o, timeout_o}, exp);
    endtask

    task automatic do_reset();
        req_i = 4'd0; done_i = 4'd0;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_eq("reset_outs", {grant_o, grant_id_o, busy_o, timeout_o}, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1);
    end

    initial begin
        int order[$];
        int zero_run, hold, guard;
        logic prev_busy;
        logic [3:0] d;

        // 1: idle after reset
        do_reset();
        repeat (20) cyc(4'b0000, 4'b0000, "t1_idle");

        // 2: single requester released by done
        for (int i = 0; i < 4; i++) cyc(4'b0010, 4'b0000, "t2_hold");
        check_eq("t2_id", grant_id_o, 32'd1);
        cyc(4'b0010, 4'b0010, "t2_done");
        check_eq("t2_drop", grant_o, 32'd0);
        cyc(4'b0000, 4'b0000, "t2_rel");
        cyc(4'b0000, 4'b0000, "t2_idle");

        // 3: all requesting, done on 2nd grant cycle -> 0,1,2,3,0 with 2-cycle gaps
        do_reset();
        prev_busy = 1'b0; zero_run = 0; guard = 0;
        while (order.size() < 5 && guard < 60) begin
            d = (m_owner >= 0 && m_cnt == 2) ? 4'(1 << m_owner) : 4'd0;
            cyc(4'b1111, d, "t3_rr");
            if (busy_o && !prev_busy) begin
                if (order.size() > 0) check_eq("t3_gap", zero_run, 32'd2);
                order.push_back(int'(grant_id_o));
            end
            zero_run  = busy_o ? 0 : zero_run + 1;
            prev_busy = busy_o;
            guard++;
        end
        check_eq("t3_count", order.size(), 32'd5);
        for (int k = 0; k < order.size(); k++) check_eq("t3_order", order[k], k % 4);
        repeat (3) cyc(4'b0000, 4'b0000, "t3_drain");

        // 4: hold budget of 8 cycles, timeout pulse, re-grant, then pointer moves on
        do_reset();
        cyc(4'b0100, 4'b0000, "t4_grant");
        hold = 0; guard = 0;
        while (grant_o != 4'd0 && guard < 20) begin
            hold++;
            cyc(4'b0100, 4'b0000, "t4_hold");
            guard++;
        end
        check_eq("t4_len", hold, 32'd8);
        check_eq("t4_timeout", timeout_o, 32'd1);
        cyc(4'b0100, 4'b0000, "t4_gap");
        check_eq("t4_to_clear", timeout_o, 32'd0);
        cyc(4'b0100, 4'b0000, "t4_regrant");
        check_eq("t4_regrant_id", grant_id_o, 32'd2);
        guard = 0;
        while (grant_o != 4'd0 && guard < 20) begin
            cyc(4'b0101, 4'b0000, "t4_hold2");
            guard++;
        end
        guard = 0;
        while (!busy_o && guard < 5) begin
            cyc(4'b0101, 4'b0000, "t4_wait");
            guard++;
        end
        check_eq("t4_next_id", grant_id_o, 32'd0);
        repeat (3) cyc(4'b0000, 4'b0000, "t4_drain");

        // 5: non-owner activity ignored, owner req drop releases
        do_reset();
        cyc(4'b0010, 4'b0000, "t5_grant");
        cyc(4'b1010, 4'b1000, "t5_noise");
        cyc(4'b0010, 4'b0000, "t5_noise");
        cyc(4'b1010, 4'b1000, "t5_noise");
        check_eq("t5_held", grant_o, 32'b0010);
        cyc(4'b1000, 4'b0000, "t5_drop");
        cyc(4'b1000, 4'b0000, "t5_rel");
        cyc(4'b1000, 4'b0000, "t5_next");
        check_eq("t5_next_id", grant_id_o, 32'd3);
        repeat (3) cyc(4'b0000, 4'b0000, "t5_drain");

        // 6: async reset mid-busy clears at once and restores pointer to 0
        cyc(4'b1111, 4'b0000, "t6_grant");
        cyc(4'b1111, 4'b0000, "t6_hold");
        #2 reset = 1'b1;
        #1;
        check_eq("t6_async", {grant_o, grant_id_o, busy_o, timeout_o}, 8'h00);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(4'b1111, 4'b0000, "t6_first");
        check_eq("t6_first_id", grant_id_o, 32'd0);
        check_eq("t6_busy", busy_o, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
